// File: rtl/mult_share_arbiter_if.sv
// Bundle of request and response signals between client blocks and the shared
// multiplier arbiter. "master" is the client side and "slave" is the arbiter side.
interface mult_share_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [8*NUM_REQ-1:0] req_a;
   logic [8*NUM_REQ-1:0] req_b;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [ID_W-1:0]      rsp_id;
   logic [15:0]          rsp_out;
   logic                 busy;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_out, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_out, busy
   );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that lets NUM_REQ clients share one registered 8x8 vedic
// multiplier. Each result comes back on one response channel, tagged with the requester ID.
module vedic_mult_8bit (
   input  logic [7:0]  a_i,
   input  logic [7:0]  b_i,
   output logic [15:0] p_o
);
   function automatic logic [3:0] vm2(input logic [1:0] a, input logic [1:0] b);
      logic x, y, z, c;
      logic [3:0] p;
      x    = a[1] & b[0];
      y    = a[0] & b[1];
      z    = a[1] & b[1];
      c    = x & y;
      p[0] = a[0] & b[0];
      p[1] = x ^ y;
      p[2] = z ^ c;
      p[3] = z & c;
      return p;
   endfunction

   function automatic logic [7:0] vm4(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] ll, lh, hl, hh;
      ll = vm2(a[1:0], b[1:0]);
      lh = vm2(a[1:0], b[3:2]);
      hl = vm2(a[3:2], b[1:0]);
      hh = vm2(a[3:2], b[3:2]);
      return {4'b0000, ll} + {2'b00, lh, 2'b00} + {2'b00, hl, 2'b00} + {hh, 4'b0000};
   endfunction

   logic [7:0] ll8, lh8, hl8, hh8;

   // Vertically-and-crosswise combination of the four 4x4 partial products.
   always_comb begin
      ll8 = vm4(a_i[3:0], b_i[3:0]);
      lh8 = vm4(a_i[3:0], b_i[7:4]);
      hl8 = vm4(a_i[7:4], b_i[3:0]);
      hh8 = vm4(a_i[7:4], b_i[7:4]);
      p_o = {8'h00, ll8} + {4'h0, lh8, 4'h0} + {4'h0, hl8, 4'h0} + {hh8, 8'h00};
   end
endmodule

module mult_share_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   mult_share_arbiter_if.slave   bus
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [7:0]      op_a_q, op_a_d;
   logic [7:0]      op_b_q, op_b_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0] rsp_id_q, rsp_id_d;
   logic [15:0]     rsp_out_q, rsp_out_d;

   logic [15:0]     product;
   logic            found;
   logic [ID_W-1:0] grant;
   logic [ID_W-1:0] next_ptr;
   logic            window;
   logic            accept;
   int              idx;

   vedic_mult_8bit u_mult (
      .a_i (op_a_q),
      .b_i (op_b_q),
      .p_o (product)
   );

   // Grant is the first valid requester at or after rr_ptr, wrapping around.
   always_comb begin
      found = 1'b0;
      grant = {ID_W{1'b0}};
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!found && bus.req_valid[idx]) begin
            found = 1'b1;
            grant = ID_W'(idx);
         end else begin
            found = found;
         end
      end
   end

   // A stalled response keeps the window shut, and reset forces req_ready low.
   always_comb begin
      window = (state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.rsp_ready);
      accept = window && found && !rst;
      if (grant == ID_W'(NUM_REQ - 1)) begin
         next_ptr = {ID_W{1'b0}};
      end else begin
         next_ptr = grant + ID_W'(1);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_ready[i] = accept && (grant == ID_W'(i));
      end
   end

   // Next-state, operand capture and response register updates.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      id_d        = id_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_out_d   = rsp_out_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_CALC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            state_d     = ST_RESP;
            rsp_out_d   = product;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (accept) begin
                  state_d = ST_CALC;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase

      if (accept) begin
         op_a_d   = bus.req_a[int'(grant)*8 +: 8];
         op_b_d   = bus.req_b[int'(grant)*8 +: 8];
         id_d     = grant;
         rr_ptr_d = next_ptr;
      end else begin
         op_a_d   = op_a_d;
         op_b_d   = op_b_d;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= {ID_W{1'b0}};
         id_q        <= {ID_W{1'b0}};
         op_a_q      <= 8'h00;
         op_b_q      <= 8'h00;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= {ID_W{1'b0}};
         rsp_out_q   <= 16'h0000;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         id_q        <= id_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_out_q   <= rsp_out_d;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_out   = rsp_out_q;
   assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one 8x8 unsigned multiplier datapath (vedic_mult_8bit, instantiated internally) between NUM_REQ requesters.
- Round-robin arbitration selects one request at a time, and operands are registered before the multiplier.
- The product is registered and returned on a single shared response channel, tagged with the requester ID.
- Sits between client blocks and the multiplier so the multiplier is never duplicated.

Parameters:
NUM_REQ, 4, number of requesters (1..16)
ID_W, max(1,$clog2(NUM_REQ)), width of requester ID (derived localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
req_a  input  8*NUM_REQ  operand A, requester i at [8i+7:8i]
req_b  input  8*NUM_REQ  operand B, requester i at [8i+7:8i]
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer accept
rsp_id  output  ID_W  requester index of current response
rsp_out  output  16  unsigned product a*b
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, active-high): state=IDLE, rr_ptr=0, operand regs=0, rsp_valid=0, rsp_id=0, rsp_out=0, req_ready=0, busy=0. Any in-flight op is discarded; no response is ever produced for it.
- FSM states: IDLE, CALC, RESP.
- Arbitration window is open when state==IDLE, or when state==RESP && rsp_ready==1.
- Grant selection in an open window:
  - grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[grant]=1, combinational from req_valid and state; all other req_ready bits are 0.
  - No valid request or window closed: req_ready=0.
- Request handshake (req_valid[g] & req_ready[g]):
  - Capture req_a/req_b slice g into operand regs and g into id reg.
  - rr_ptr <= (g+1) mod NUM_REQ; next state=CALC.
- IDLE, no request: stay in IDLE.
- CALC:
  - Multiplier sees the operand regs.
  - Next edge: rsp_out <= product, rsp_id <= id reg, rsp_valid <= 1, state=RESP.
  - req_ready=0 throughout CALC.
- RESP:
  - rsp_valid=1; rsp_out and rsp_id held stable until the handshake.
  - rsp_ready=0: stay in RESP, no arbitration.
  - rsp_ready=1 with no req_valid: rsp_valid<=0, state=IDLE.
  - rsp_ready=1 with a req_valid: the response handshake and a new request acceptance happen in the same cycle; state=CALC, rsp_valid<=0.
- Latency and throughput:
  - Request accepted in cycle T gives rsp_valid high in cycle T+2 (absent reset).
  - Sustained throughput is one op per 2 cycles with rsp_ready tied high.
- Arithmetic: unsigned, full 16-bit, no truncation (max 255*255=65025=0xFE01).
- Requester protocol: req_valid and its operands must stay stable until req_ready. The arbiter does not latch unaccepted requests, and a dropped valid simply loses arbitration.
- rr_ptr advances only on a request handshake, never on idle cycles.
- NUM_REQ=1: grant is always 0, rsp_id=0.
- A request arriving during CALC or a stalled RESP waits; it is not accepted until the next open window.

Test Plan:
- Single request: requester 2 sends a=13, b=11 from IDLE -> req_ready[2]=1 same cycle; two cycles later rsp_valid=1, rsp_out=143, rsp_id=2; busy high from cycle after accept until response taken.
- Corners: a=255,b=255 -> rsp_out=65025. a=0,b=200 -> 0. a=1,b=128 -> 128.
- Full contention, rr_ptr=0, all four valid with a=i+1,b=10, rsp_ready=1:
  - Grants come in order 0,1,2,3,0, with rsp_id matching and products 10,20,30,40.
  - A new accept occurs every 2 cycles, coinciding with each response handshake.
- Backpressure: response 7*9 pending, rsp_ready=0 for 5 cycles with requester 1 valid -> rsp_out=63 and rsp_id held; req_ready=0 throughout; accept occurs in the cycle rsp_ready rises.
- Reset mid-op: assert rst in CALC after accepting 5*5 -> all outputs 0 immediately, with no response after release; rr_ptr=0, so with requesters 0 and 3 valid the first grant is 0.
- Fairness skip: rr_ptr=1, only requesters 0 and 3 valid -> grant 3, then 0; rr_ptr unchanged across idle cycles between requests.
